mask_loader: RTL
================

// Module: mask_loader
// PURPOSE
//  Command sequencer that programs the five 64-bit trigger masks (5 masks x 8 bytes).
//  Parses a byte stream from the host link (valid/ready) into LOAD and FILL packets.
//  Buffers each LOAD payload, then drives one Mask write per cycle (we/P0/P1/P2).
//  Sits between the host command decoder and the Mask register file.
// PARAMETERS
//  NUM_MASKS       5        number of masks; a valid index is 0..NUM_MASKS-1
//  BYTES_PER_MASK  8        bytes per mask; P1 runs 0..BYTES_PER_MASK-1
//  OP_LOAD         8'h01    opcode: write one mask from 8 payload bytes
//  OP_FILL         8'h02    opcode: write one fill byte to a mask, or to all masks
//  TIMEOUT_CYCLES  1000000  maximum gap between bytes of one packet, in cycles
// PORTS
//  in_clk        in   1  system clock
//  in_rst_n      in   1  asynchronous active-low reset
//  in_data       in   8  command byte
//  in_valid      in   1  in_data valid
//  out_ready     out  1  byte accepted on a cycle with in_valid && out_ready
//  out_we        out  1  Mask write enable (registered)
//  out_P0        out  8  mask index (registered)
//  out_P1        out  8  byte index within mask (registered)
//  out_P2        out  8  byte to write (registered)
//  out_busy      out  1  high in any state other than IDLE
//  out_done      out  1  1-cycle pulse when a packet completes without error
//  out_err       out  1  sticky error; cleared when the next opcode byte is accepted
//  out_err_code  out  2  0 bad opcode, 1 bad index, 2 timeout, 3 checksum
// BEHAVIOUR
//  Reset (async, in_rst_n=0):
//   - state IDLE; out_we, out_P0, out_P1, out_P2, out_done, out_err, out_err_code, out_busy = 0
//   - out_ready = 0 while reset is held; 1 in the first cycle after release
//   - payload buffer is not reset
//  Packet formats:
//   - LOAD: op, idx, d0..d7
//   - FILL: op, idx, fill
//  States and transitions:
//   - IDLE: accept op. Unknown op -> err code 0, byte dropped, stay in IDLE.
//   - GET_IDX: accept idx.
//   - GET_DATA: LOAD takes 8 bytes into buf[0..7]; FILL takes 1 byte.
//   - COMMIT (LOAD): writes start the cycle after the last byte is accepted.
//     Writes P0=idx, P1=0..7 in ascending order, P2=buf[P1], one per cycle; 8 cycles total.
//   - FILL: idx<NUM_MASKS gives 8 writes to that mask.
//     idx=8'hFF gives 40 writes, mask-major order (P0 0..4, P1 0..7 within each).
//   - End of packet: out_done pulses the cycle after the last out_we, then state returns to IDLE.
//  Handshake:
//   - out_ready = 1 only in IDLE, GET_IDX, GET_DATA and GET_CSUM.
//   - out_ready = 0 during COMMIT and FILL; input stalls, no byte is lost.
//  Bad index (idx >= NUM_MASKS and not FILL 8'hFF):
//   - remaining payload bytes (and checksum byte, if built) are consumed
//   - no writes are issued
//   - err code 1, no out_done
//  Timeout:
//   - inter-byte counter sized $clog2(TIMEOUT_CYCLES+1); counts in GET_* states, restarts on every accepted byte
//   - at TIMEOUT_CYCLES: -> IDLE, err code 2, partial packet discarded
//  Error latching: a later error overwrites out_err_code.
//  Reset mid-COMMIT/FILL:
//   - out_we drops immediately
//   - bytes already written stay in Mask; no rollback
//  out_we = 0 in all cycles other than COMMIT/FILL write cycles; P0/P1/P2 hold their last values.
// CONFIGURATION
//  MASK_LOADER_CHECKSUM_EN defined:
//   - packets carry a trailing checksum byte, taken in state GET_CSUM
//   - checksum = XOR of op, idx and all payload bytes
//   - match: writes proceed
//   - mismatch: zero writes, err code 3, -> IDLE
//  MASK_LOADER_CHECKSUM_EN undefined:
//   - no GET_CSUM state
//   - the packet ends at the last payload byte
// TESTING
//  - LOAD mask 2, bytes 11..88, in_valid held high:
//    -> 8 writes P0=2, P1=0..7, P2=11..88; done pulse; out_ready low for 8 cycles.
//  - FILL idx FF, fill 00:
//    -> 40 consecutive writes, P0/P1 mask-major, P2=00; single done pulse; busy low afterwards.
//  - Opcode 7 followed by a valid LOAD:
//    -> err=1, code 0 after the first byte; err clears when the LOAD op is accepted; LOAD completes normally.
//  - LOAD idx 5:
//    -> all 8 payload bytes accepted; no out_we; err code 1; returns to IDLE.
//  - LOAD op, idx 0, 3 data bytes, then gap of TIMEOUT_CYCLES (bench sets it to 16):
//    -> IDLE, err code 2, no writes.
//  - Reset pulse on the 4th write of a LOAD:
//    -> out_we=0 asynchronously; all outputs 0; with CHECKSUM_EN, a bad checksum gives code 3 and no writes.

Source files
------------

// File: rtl/mask_loader_if.sv
// Host byte link plus Mask write port and status of the mask_loader sequencer.
// The master side feeds command bytes; the slave side is the sequencer itself.
interface mask_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       out_ready;
   logic       out_we;
   logic [7:0] out_P0;
   logic [7:0] out_P1;
   logic [7:0] out_P2;
   logic       out_busy;
   logic       out_done;
   logic       out_err;
   logic [1:0] out_err_code;

   modport master (
      output in_data, in_valid,
      input  out_ready, out_we, out_P0, out_P1, out_P2,
      input  out_busy, out_done, out_err, out_err_code
   );

   modport slave (
      input  in_data, in_valid,
      output out_ready, out_we, out_P0, out_P1, out_P2,
      output out_busy, out_done, out_err, out_err_code
   );
endinterface

// File: rtl/mask_loader.sv
// Parses LOAD/FILL command packets and drives one trigger-mask byte write per cycle.
// Define MASK_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per packet.
module mask_loader #(
   parameter int         NUM_MASKS      = 5,
   parameter int         BYTES_PER_MASK = 8,
   parameter logic [7:0] OP_LOAD        = 8'h01,
   parameter logic [7:0] OP_FILL        = 8'h02,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input logic          in_clk,
   input logic          in_rst_n,
   mask_loader_if.slave bus
);
   localparam int BI_W  = (BYTES_PER_MASK > 1) ? $clog2(BYTES_PER_MASK) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [BI_W-1:0]  LAST_IDX    = BI_W'(BYTES_PER_MASK - 1);
   localparam logic [7:0]       LAST_BYTE   = 8'(BYTES_PER_MASK - 1);
   localparam logic [7:0]       LAST_MASK   = 8'(NUM_MASKS - 1);
   localparam logic [7:0]       NUM_MASKS_B = 8'(NUM_MASKS);
   localparam logic [7:0]       IDX_ALL     = 8'hFF;
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, GET_IDX, GET_DATA,
`ifdef MASK_LOADER_CHECKSUM_EN
      GET_CSUM,
`endif
      COMMIT, FILL
   } state_t;

   typedef enum logic [1:0] {ERR_OP = 2'd0, ERR_IDX = 2'd1, ERR_TMO = 2'd2, ERR_CSUM = 2'd3} err_t;

   state_t          state;
   err_t            code_r;
   logic            is_fill, idx_bad, we_r, done_r, err_r;
   logic [7:0]      idx_r, p0_r, p1_r, p2_r;
   logic [BI_W-1:0] byte_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]      pay_buf [BYTES_PER_MASK];

   logic       in_get, accept, last_data, pkt_end, fill_all;
   logic [7:0] first_p2, p1_nxt;

`ifdef MASK_LOADER_CHECKSUM_EN
   logic [7:0] csum_r;
   logic       pkt_ok;
   assign in_get   = state inside {GET_IDX, GET_DATA, GET_CSUM};
   assign pkt_end  = accept && (state == GET_CSUM);
   assign pkt_ok   = (csum_r == bus.in_data);
   assign first_p2 = pay_buf[0];
`else
   assign in_get   = state inside {GET_IDX, GET_DATA};
   assign pkt_end  = accept && (state == GET_DATA) && last_data;
   // Without a checksum the last payload byte is still on the bus when writes start.
   assign first_p2 = (byte_cnt == '0) ? bus.in_data : pay_buf[0];
`endif

   assign accept    = bus.in_valid && bus.out_ready;
   assign last_data = is_fill || (byte_cnt == LAST_IDX);
   assign fill_all  = is_fill && (idx_r == IDX_ALL);
   assign p1_nxt    = p1_r + 8'd1;

   assign bus.out_ready    = in_rst_n && ((state == IDLE) || in_get);
   assign bus.out_busy     = (state != IDLE);
   assign bus.out_we       = we_r;
   assign bus.out_P0       = p0_r;
   assign bus.out_P1       = p1_r;
   assign bus.out_P2       = p2_r;
   assign bus.out_done     = done_r;
   assign bus.out_err      = err_r;
   assign bus.out_err_code = code_r;

   // NOTE: the payload buffer has no reset; every entry is written before it is read.
   always_ff @(posedge in_clk) begin
      if (accept && (state == GET_DATA)) pay_buf[byte_cnt] <= bus.in_data;
   end

   // NOTE: all state uses non-blocking assignments; later assignments in this block
   // deliberately override earlier ones (timeout and packet end take precedence).
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state    <= IDLE;
         code_r   <= ERR_OP;
         is_fill  <= 1'b0;
         idx_bad  <= 1'b0;
         we_r     <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         idx_r    <= '0;
         p0_r     <= '0;
         p1_r     <= '0;
         p2_r     <= '0;
         byte_cnt <= '0;
         tmo_cnt  <= '0;
`ifdef MASK_LOADER_CHECKSUM_EN
         csum_r   <= '0;
`endif
      end else begin
         done_r <= 1'b0;
         if (accept)      tmo_cnt <= '0;
         else if (in_get) tmo_cnt <= tmo_cnt + 1'b1;
`ifdef MASK_LOADER_CHECKSUM_EN
         if (accept) csum_r <= (state == IDLE) ? bus.in_data : (csum_r ^ bus.in_data);
`endif
         case (state)
            IDLE: if (accept) begin
               if ((bus.in_data == OP_LOAD) || (bus.in_data == OP_FILL)) begin
                  is_fill <= (bus.in_data == OP_FILL);
                  err_r   <= 1'b0;
                  state   <= GET_IDX;
               end else begin
                  err_r  <= 1'b1;
                  code_r <= ERR_OP;
               end
            end
            GET_IDX: if (accept) begin
               idx_r    <= bus.in_data;
               idx_bad  <= !((bus.in_data < NUM_MASKS_B) || (is_fill && (bus.in_data == IDX_ALL)));
               byte_cnt <= '0;
               state    <= GET_DATA;
            end
            GET_DATA: if (accept) begin
               if (!last_data) byte_cnt <= byte_cnt + 1'b1;
`ifdef MASK_LOADER_CHECKSUM_EN
               else            state    <= GET_CSUM;
`endif
            end
            COMMIT, FILL: begin
               if (p1_r == LAST_BYTE) begin
                  if ((state == FILL) && fill_all && (p0_r != LAST_MASK)) begin
                     p0_r <= p0_r + 8'd1;
                     p1_r <= '0;
                  end else begin
                     we_r   <= 1'b0;
                     done_r <= 1'b1;
                     state  <= IDLE;
                  end
               end else begin
                  p1_r <= p1_nxt;
                  if (state == COMMIT) p2_r <= pay_buf[p1_nxt[BI_W-1:0]];
               end
            end
            default: state <= IDLE;
         endcase

         if (in_get && !accept && (tmo_cnt == TMO_LAST)) begin
            state  <= IDLE;
            err_r  <= 1'b1;
            code_r <= ERR_TMO;
         end

         if (pkt_end) begin
            if (idx_bad) begin
               state  <= IDLE;
               err_r  <= 1'b1;
               code_r <= ERR_IDX;
`ifdef MASK_LOADER_CHECKSUM_EN
            end else if (!pkt_ok) begin
               state  <= IDLE;
               err_r  <= 1'b1;
               code_r <= ERR_CSUM;
`endif
            end else begin
               we_r  <= 1'b1;
               p0_r  <= fill_all ? 8'd0 : idx_r;
               p1_r  <= '0;
               p2_r  <= first_p2;
               state <= is_fill ? FILL : COMMIT;
            end
         end
      end
   end
endmodule
